// File: rtl/pulse_cmd_sched.sv
// pulse_cmd_sched: merges host commands and an internal delay-sweep sequencer
// onto the pulse generator's 32-bit command FIFO write port.
// Word layout: [31:24] opcode, [23:8] coarse delay, [7:0] fine delay.
// Optional build macro HOST_LOCK_EN: when defined, host words are held off
// while a sweep is active so the calibration pattern lands contiguously.
//
// state     | meaning
// S_IDLE    | no sweep; waiting for sweep_start
// S_RST_CLK | requesting the clock-reset word (0x00000000)
// S_SET_PER | requesting the set-period word {0x02, period}
// S_PULSE   | requesting send_pulse words over the coarse x fine grid
// S_DONE    | one-cycle sweep_done pulse, then back to idle
module pulse_cmd_sched #(
    parameter int FINE_MAX = 15,
    parameter int REPEAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_cmd_valid,
    input  logic [31:0] host_cmd_data,
    output logic        host_cmd_ready,
    input  logic        sweep_start,
    input  logic        sweep_abort,
    input  logic [23:0] sweep_period,
    input  logic [15:0] sweep_coarse_start,
    input  logic [15:0] sweep_coarse_end,
    output logic        sweep_busy,
    output logic        sweep_done,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST_CLK = 3'd1,
        S_SET_PER = 3'd2,
        S_PULSE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] FINE_LAST = 8'(FINE_MAX);
    localparam logic [7:0] REP_LAST  = 8'(REPEAT - 1);

    localparam logic [7:0] OP_RST_CLK = 8'h00;
    localparam logic [7:0] OP_PULSE   = 8'h01;
    localparam logic [7:0] OP_SET_PER = 8'h02;

    state_t      state_q, state_d;
    logic [23:0] period_q, period_d;
    logic [15:0] coarse_end_q, coarse_end_d;
    // One extra bit so the end compare never sees a wrapped counter.
    logic [16:0] coarse_cnt_q, coarse_cnt_d;
    logic [7:0]  fine_cnt_q, fine_cnt_d;
    logic [7:0]  rep_cnt_q, rep_cnt_d;
    // 1 = sweep owned the last write; reset value lets the host win first.
    logic        last_grant_sweep_q, last_grant_sweep_d;

    logic        host_req;
    logic        sweep_req;
    logic        grant_host;
    logic        grant_sweep;
    logic        sweep_wr;
    logic [31:0] sweep_word;

    // Request generation, arbitration and the zero-latency write path.
    always_comb begin
        sweep_busy = (state_q != S_IDLE);
        sweep_done = (state_q == S_DONE);
`ifdef HOST_LOCK_EN
        host_req   = host_cmd_valid & ~sweep_busy;
`else
        host_req   = host_cmd_valid;
`endif
        sweep_req  = (state_q == S_RST_CLK) || (state_q == S_SET_PER) ||
                     (state_q == S_PULSE);

        sweep_word = 32'h0;
        case (state_q)
            S_RST_CLK: sweep_word = {OP_RST_CLK, 24'h0};
            S_SET_PER: sweep_word = {OP_SET_PER, period_q};
            S_PULSE:   sweep_word = {OP_PULSE, coarse_cnt_q[15:0], fine_cnt_q};
            default:   sweep_word = 32'h0;
        endcase

        grant_host  = host_req & (~sweep_req | last_grant_sweep_q);
        grant_sweep = sweep_req & ~grant_host;

        // rst gates the write path so outputs drop immediately on assertion,
        // even with a host word pending.
        fifo_wr_en     = ~fifo_full & ~rst & (host_req | sweep_req);
        fifo_wr_data   = 32'h0;
        if (fifo_wr_en) begin
            fifo_wr_data = grant_host ? host_cmd_data : sweep_word;
        end
        host_cmd_ready = fifo_wr_en & grant_host;
        sweep_wr       = fifo_wr_en & grant_sweep;

        last_grant_sweep_d = fifo_wr_en ? grant_sweep : last_grant_sweep_q;
    end

    // Sweep sequencer next-state and counter updates.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        coarse_end_d = coarse_end_q;
        coarse_cnt_d = coarse_cnt_q;
        fine_cnt_d   = fine_cnt_q;
        rep_cnt_d    = rep_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (sweep_start && !sweep_abort) begin
                    period_d     = sweep_period;
                    coarse_end_d = sweep_coarse_end;
                    coarse_cnt_d = {1'b0, sweep_coarse_start};
                    fine_cnt_d   = 8'd0;
                    rep_cnt_d    = 8'd0;
                    state_d      = S_RST_CLK;
                end
            end
            S_RST_CLK: begin
                if (sweep_wr) begin
                    state_d = S_SET_PER;
                end
            end
            S_SET_PER: begin
                // coarse_cnt still holds the start value here.
                if (sweep_wr) begin
                    state_d = ({1'b0, coarse_end_q} >= coarse_cnt_q) ? S_PULSE : S_DONE;
                end
            end
            S_PULSE: begin
                if (sweep_wr) begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_cnt_d = 8'd0;
                        if (fine_cnt_q == FINE_LAST) begin
                            fine_cnt_d = 8'd0;
                            if (coarse_cnt_q == {1'b0, coarse_end_q}) begin
                                state_d = S_DONE;
                            end else begin
                                coarse_cnt_d = coarse_cnt_q + 17'd1;
                            end
                        end else begin
                            fine_cnt_d = fine_cnt_q + 8'd1;
                        end
                    end else begin
                        rep_cnt_d = rep_cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A word granted this cycle still goes out; only the follow-on stops.
        if (sweep_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            period_q           <= 24'h0;
            coarse_end_q       <= 16'h0;
            coarse_cnt_q       <= 17'h0;
            fine_cnt_q         <= 8'h0;
            rep_cnt_q          <= 8'h0;
            last_grant_sweep_q <= 1'b1;
        end else begin
            state_q            <= state_d;
            period_q           <= period_d;
            coarse_end_q       <= coarse_end_d;
            coarse_cnt_q       <= coarse_cnt_d;
            fine_cnt_q         <= fine_cnt_d;
            rep_cnt_q          <= rep_cnt_d;
            last_grant_sweep_q <= last_grant_sweep_d;
        end
    end

endmodule

// File: doc/pulse_cmd_sched.md
Name: pulse_cmd_sched

Overview:
- Command scheduler in front of the pulse generator's 32-bit command FIFO.
- Merges two command sources into one FIFO write port:
  - a host command stream (valid/ready);
  - an internal delay-sweep sequencer that emits a full calibration pattern: clock reset, period set, then send_pulse over a coarse × fine delay grid.
- Round-robin arbitration, FIFO-full backpressure, one FIFO word per cycle maximum.

Parameters:
- FINE_MAX, 15, last fine-delay index swept; fine runs 0..FINE_MAX (16-bit samples in a 256-bit beat).
- REPEAT, 1, send_pulse words emitted per (coarse, fine) point; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- host_cmd_valid  in  1  host word pending
- host_cmd_data  in  32  host word: [31:24] cmd, [23:8] coarse, [7:0] fine
- host_cmd_ready  out  1  host word accepted this cycle
- sweep_start  in  1  single-cycle start strobe
- sweep_abort  in  1  single-cycle abort strobe
- sweep_period  in  24  clock period written by the sweep
- sweep_coarse_start  in  16  first coarse delay
- sweep_coarse_end  in  16  last coarse delay, inclusive
- sweep_busy  out  1  sweep active
- sweep_done  out  1  one-cycle pulse after the last sweep word is written
- fifo_full  in  1  pulse-generator FIFO full
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  32  FIFO write word

Behaviour:
- Reset: all state cleared, sweep FSM in S_IDLE, last_grant = sweep (so host wins first contention). Outputs host_cmd_ready, sweep_busy, sweep_done, fifo_wr_en = 0 and fifo_wr_data = 0. Reset mid-sweep abandons the sweep with no sweep_done.
- Opcodes: 0x00 reset clock, 0x01 send pulse, 0x02 set period, 0x03 / 0x04 phase-measurement mode set / clear. Host words are passed through unchecked.
- Write path (combinational, zero latency):
  - fifo_wr_en = !fifo_full & (host_req | sweep_req);
  - fifo_wr_data = word of the granted source, else 0;
  - host_cmd_ready = fifo_wr_en & grant_host.
  - A sweep word advances only on a cycle with fifo_wr_en & grant_sweep.
- Arbitration:
  - One requester pending: it is granted.
  - Both pending: grant the source not in last_grant.
  - last_grant updates only on an actual write.
  - fifo_full stalls both sources; no state changes.
- Sweep FSM:
  - S_IDLE: sweep_start → latch period, coarse_start and coarse_end; coarse_cnt = start, fine_cnt = 0, rep_cnt = 0; go to S_RST_CLK. sweep_busy = 1 in every state except S_IDLE.
  - S_RST_CLK: request 0x00000000; on write → S_SET_PER.
  - S_SET_PER: request {0x02, period}; on write → S_PULSE if coarse_end >= coarse_start, else S_DONE.
  - S_PULSE: request {0x01, coarse_cnt, fine_cnt}. On each write:
    - rep_cnt++;
    - when rep_cnt reaches REPEAT-1: rep_cnt = 0, fine_cnt++;
    - when fine_cnt reaches FINE_MAX: fine_cnt = 0, coarse_cnt++;
    - when coarse_cnt equals coarse_end: → S_DONE.
    - The coarse compare uses 17-bit width, so coarse_end = 0xFFFF terminates with no wrap.
  - S_DONE: sweep_done = 1 for exactly one cycle, then → S_IDLE.
- Word count for a non-empty sweep: 2 + (end-start+1)·(FINE_MAX+1)·REPEAT. For an empty range (end < start): 2 words, then done.
- sweep_start while busy: ignored. Sweep parameters are not re-latched.
- sweep_abort: from any busy state → S_IDLE next cycle, no further sweep words, no sweep_done.
  - A word granted in the abort cycle is still written.
  - Abort and start in the same idle cycle: abort wins; no sweep starts.
- Host words are never reordered or dropped. host_cmd_data must stay stable while valid and not ready.

Optional Feature:
- Macro HOST_LOCK_EN.
- Defined: host_req is forced to 0 while sweep_busy (host_cmd_ready = 0), so the sweep pattern is contiguous in the FIFO.
- Undefined: round-robin interleaving as above.

Test Plan:
- Host only, fifo_full = 0: host words 0x01000A03 and 0x02000010 → written on consecutive cycles, ready high on both, data unchanged.
- Sweep with period = 0x000064, start = 5, end = 6, REPEAT = 1 → 34 words in order: 0x00000000, 0x02000064, 0x01000500..0x0100050F, 0x01000600..0x0100060F; sweep_done pulses once; busy falls on the following cycle.
- Host and sweep contending, fifo_full = 0 → writes alternate host/sweep; host first after reset.
- fifo_full held high 10 cycles mid-sweep → no writes, counters frozen; resumes with the next expected word, none skipped or duplicated.
- sweep_abort after 3 sweep words → idle, no sweep_done. Empty range (start = 9, end = 8) → 2 words, then done.
- rst asserted mid-sweep → all outputs 0 asynchronously. With HOST_LOCK_EN defined, host_cmd_ready stays 0 for the whole sweep.
